// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared types for the parametrised SPI master.
//                - spi_state_t : transfer sequencer states
//                - spi_mode_t  : per-transfer mode captured at accept
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // IDLE  : bus parked, waiting for a start request
    // LEAD  : chip select asserted, first data bit on MOSI, one half-period
    // XFER  : 2*DATA_W half-periods of SCLK activity
    // TRAIL : SCLK back at idle level, chip select still asserted
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_t;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic lsb_first;
    } spi_mode_t;

    // Returns the bit that goes on the wire first for a given bit order.
    function automatic logic first_out(input logic lsb_first,
                                       input logic msb_bit,
                                       input logic lsb_bit);
        return lsb_first ? lsb_bit : msb_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_clkgen.sv
`default_nettype none
// ============================================================================
//  Module      : spi_clkgen
//  Description : Half-period timer for the SPI master. While enabled it
//                emits a one-cycle tick every (div+1) clk cycles. The count
//                is held at zero while disabled, so every enable rising edge
//                starts a fresh half-period.
//  Ports       : clk   - system clock
//                reset - asynchronous, active-low reset
//                en    - run the timer
//                div   - half-period length minus one (latched by parent)
//                tick  - end of the current half-period
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             w_tick;

    // Tick is combinational so the parent acts on the very edge that closes
    // the half-period, giving an exact H-cycle spacing.
    assign w_tick = en && (r_cnt == div);
    assign tick   = w_tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (!en || w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_master_n.sv
`default_nettype none
// ============================================================================
//  Module      : spi_master_n
//  Description : Parametrised SPI master. One word per start/done handshake,
//                runtime CPOL/CPHA, bit order and SCLK divider, one
//                active-low chip select per slave. MISO arrives already
//                muxed from the slave side.
//  Ports       : clk, reset (async, active-low)
//                start, slave_sel, cpol, cpha, lsb_first, clk_div, tx_data
//                                  - request + configuration, sampled at accept
//                rx_data           - last received word, updated with done
//                busy, done        - status / one-cycle completion pulse
//                sclk, mosi, miso  - SPI bus
//                cs_n              - active-low slave selects
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_master_n
    import spi_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_SLAVES = 4,
    parameter int DIV_W      = 8,
    parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [SEL_W-1:0]      slave_sel,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [DIV_W-1:0]      clk_div,
    input  logic [DATA_W-1:0]     tx_data,
    output logic [DATA_W-1:0]     rx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_SLAVES-1:0] cs_n
);

    // Edge counter must hold 0..2*DATA_W.
    localparam int                 c_CNT_W      = $clog2(2 * DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_FIRST_EDGE = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_LAST_EDGE  = c_CNT_W'(2 * DATA_W);

    spi_state_t            r_state;
    spi_state_t            w_state_nxt;
    spi_mode_t             r_mode;
    logic [DIV_W-1:0]      r_div;
    logic [DATA_W-1:0]     r_tx;
    logic [DATA_W-1:0]     r_rx;
    logic [DATA_W-1:0]     r_rx_data;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_done;
    logic [NUM_SLAVES-1:0] r_cs_n;

    logic                  w_tick;
    logic                  w_accept;
    logic                  w_edge;
    logic                  w_finish;
    logic [c_CNT_W-1:0]    w_edge_num;
    logic                  w_leading;
    logic                  w_sample;
    logic                  w_drive;
    logic [DATA_W-1:0]     w_tx_shift;
    logic                  w_tx_next;
    logic [DATA_W-1:0]     w_rx_shift;
    logic [NUM_SLAVES-1:0] w_cs_sel;

    // ------------------------------------------------------------------
    // Half-period timer: runs for the whole LEAD/XFER/TRAIL window.
    // ------------------------------------------------------------------
    spi_clkgen #(
        .DIV_W (DIV_W)
    ) u_clkgen (
        .clk   (clk),
        .reset (reset),
        .en    (r_state != IDLE),
        .div   (r_div),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and per-cycle strobes
    //   w_accept : start taken in IDLE
    //   w_edge   : an SCLK edge happens on this clk edge
    //   w_finish : transfer completes on this clk edge
    // The LEAD tick produces SCLK edge 1; XFER ticks produce edges
    // 2..2*DATA_W, after which the final XFER half-period ends without a
    // toggle (SCLK is already back at idle) and TRAIL follows.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_edge      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = LEAD;
                end
            end
            LEAD: begin
                if (w_tick) begin
                    w_edge      = 1'b1;
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (w_tick) begin
                    if (r_cnt == c_LAST_EDGE) begin
                        w_state_nxt = TRAIL;
                    end else begin
                        w_edge = 1'b1;
                    end
                end
            end
            TRAIL: begin
                if (w_tick) begin
                    w_finish    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Edge classification. Odd-numbered edges are leading edges.
    // CPHA=0 samples on leading, CPHA=1 on trailing; the other edge class
    // drives the next bit. The first bit is already on MOSI from LEAD, so
    // edge 1 never shifts, and the last edge never shifts either, which
    // keeps MOSI parked on the final data bit.
    // ------------------------------------------------------------------
    assign w_edge_num = r_cnt + c_FIRST_EDGE;
    assign w_leading  = w_edge_num[0];
    assign w_sample   = w_edge && (w_leading ^ r_mode.cpha);
    assign w_drive    = w_edge && !(w_leading ^ r_mode.cpha)
                        && (w_edge_num != c_FIRST_EDGE)
                        && (w_edge_num != c_LAST_EDGE);

    assign w_tx_shift = r_mode.lsb_first ? (r_tx >> 1) : (r_tx << 1);
    assign w_tx_next  = first_out(r_mode.lsb_first,
                                  w_tx_shift[DATA_W-1], w_tx_shift[0]);

    // LSB-first words fill from the top so the first bit lands in bit 0.
    assign w_rx_shift = r_mode.lsb_first ? {miso, r_rx[DATA_W-1:1]}
                                         : {r_rx[DATA_W-2:0], miso};

    // Out-of-range selects leave every chip select high (dummy clocks).
    always_comb begin
        w_cs_sel = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (slave_sel == SEL_W'(i)) begin
                w_cs_sel[i] = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mode    <= '0;
            r_div     <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
            r_rx_data <= '0;
            r_cnt     <= '0;
            r_sclk    <= 1'b0;
            r_mosi    <= 1'b0;
            r_done    <= 1'b0;
            r_cs_n    <= '1;
        end else begin
            r_done <= 1'b0;

            // Parked SCLK tracks the requested polarity one cycle late, so
            // it is already at the new idle level before the first edge.
            if (r_state == IDLE) begin
                r_sclk <= cpol;
            end

            if (w_accept) begin
                r_mode.cpol      <= cpol;
                r_mode.cpha      <= cpha;
                r_mode.lsb_first <= lsb_first;
                r_div            <= clk_div;
                r_tx             <= tx_data;
                r_rx             <= '0;
                r_cnt            <= '0;
                r_cs_n           <= w_cs_sel;
                r_mosi           <= first_out(lsb_first, tx_data[DATA_W-1],
                                              tx_data[0]);
            end

            if (w_edge) begin
                r_sclk <= ~r_sclk;
                r_cnt  <= w_edge_num;
            end

            if (w_sample) begin
                r_rx <= w_rx_shift;
            end

            if (w_drive) begin
                r_tx   <= w_tx_shift;
                r_mosi <= w_tx_next;
            end

            if (w_finish) begin
                r_sclk    <= r_mode.cpol;
                r_cs_n    <= '1;
                r_rx_data <= r_rx;
                r_done    <= 1'b1;
            end
        end
    end

    assign busy    = (r_state != IDLE);
    assign done    = r_done;
    assign rx_data = r_rx_data;
    assign sclk    = r_sclk;
    assign mosi    = r_mosi;
    assign cs_n    = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_master_n
//  Description : Directed self-checking bench for spi_master_n
//                (DATA_W=8, NUM_SLAVES=4, 3-bit slave_sel so that
//                out-of-range selects can be exercised).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_master_n;

    logic       clk;
    logic       reset;
    logic       start;
    logic [2:0] slave_sel;
    logic       cpol;
    logic       cpha;
    logic       lsb_first;
    logic [7:0] clk_div;
    logic [7:0] tx_data;
    logic [7:0] rx_data;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       mosi;
    logic       miso;
    logic [3:0] cs_n;

    // Slave model / bus monitor state
    logic       loop;
    logic [7:0] s_word;
    logic       s_lsb;
    logic [3:0] s_idx;
    logic       mon_clr;
    logic       sclk_q;
    logic [7:0] rise_bits;
    int         rise_cnt;
    int         edge_cnt;
    int         done_cnt;
    logic [3:0] cs_and;
    logic [3:0] cs_or;

    int n_cmp;
    int n_bad;
    int lat;

    spi_master_n #(
        .DATA_W     (8),
        .NUM_SLAVES (4),
        .DIV_W      (8),
        .SEL_W      (3)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .slave_sel (slave_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .clk_div   (clk_div),
        .tx_data   (tx_data),
        .rx_data   (rx_data),
        .busy      (busy),
        .done      (done),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .cs_n      (cs_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Mode-0 slave: presents its first bit when the transfer opens and
    // advances one bit per falling SCLK edge. Loopback mode ties MISO=MOSI.
    assign miso = loop ? mosi
                : (s_lsb ? s_word[s_idx[2:0]] : s_word[3'd7 - s_idx[2:0]]);

    always @(negedge clk) begin
        sclk_q <= sclk;
        if (!busy) begin
            s_idx <= 4'd0;
        end else if (sclk_q && !sclk) begin
            s_idx <= s_idx + 4'd1;
        end
        if (mon_clr) begin
            rise_bits <= 8'h00;
            rise_cnt  <= 0;
            edge_cnt  <= 0;
            done_cnt  <= 0;
            cs_and    <= 4'hF;
            cs_or     <= 4'h0;
        end else begin
            if (busy) begin
                if (sclk != sclk_q) edge_cnt <= edge_cnt + 1;
                if (sclk && !sclk_q) begin
                    rise_bits <= {rise_bits[6:0], mosi};
                    rise_cnt  <= rise_cnt + 1;
                end
                cs_and <= cs_and & cs_n;
                cs_or  <= cs_or | cs_n;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setup(input logic [2:0] sel, input logic pol,
                         input logic pha, input logic lsb,
                         input logic [7:0] div, input logic [7:0] tx,
                         input logic lp, input logic [7:0] sw,
                         input logic slsb);
        slave_sel = sel;
        cpol      = pol;
        cpha      = pha;
        lsb_first = lsb;
        clk_div   = div;
        tx_data   = tx;
        loop      = lp;
        s_word    = sw;
        s_lsb     = slsb;
        mon_clr   = 1'b1;
        @(posedge clk); #1;
        mon_clr   = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < 4000) begin
            @(posedge clk); #1;
            cycles++;
        end
    endtask

    task automatic launch(output int cycles);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        wait_done(cycles);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b0;
        start = 1'b0;
        slave_sel = 3'd0;
        cpol = 1'b0;
        cpha = 1'b0;
        lsb_first = 1'b0;
        clk_div = 8'd0;
        tx_data = 8'h00;
        loop = 1'b1;
        s_word = 8'h00;
        s_lsb = 1'b0;
        mon_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_rx", rx_data, 8'h00);
        chk("rst_cs_n", cs_n, 4'hF);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        mon_clr = 1'b0;

        // Mode 0, div 0, slave 2 returning 0x3C, sending 0xA5
        setup(3'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'hA5, 1'b0, 8'h3C, 1'b0);
        chk("m0_cs_lead", cs_n, 4'hF);
        launch(lat);
        chk("m0_latency", lat, 18);
        chk("m0_rx", rx_data, 8'h3C);
        chk("m0_busy_done", busy, 1'b0);
        chk("m0_cs_done", cs_n, 4'hF);
        chk("m0_mosi_rises", rise_bits, 8'hA5);
        chk("m0_rise_cnt", rise_cnt, 8);
        chk("m0_cs_and", cs_and, 4'b1011);
        chk("m0_cs_or", cs_or, 4'b1011);
        @(posedge clk); #1;
        chk("m0_done_pulse", done, 1'b0);
        chk("m0_done_cnt", done_cnt, 1);

        // All four modes, div 3, loopback 0x81
        for (int m = 0; m < 4; m++) begin
            setup(3'd1, m[1], m[0], 1'b0, 8'd3, 8'h81, 1'b1, 8'h00, 1'b0);
            chk("mode_idle_sclk", sclk, m[1]);
            launch(lat);
            chk("mode_latency", lat, 72);
            chk("mode_rx", rx_data, 8'h81);
            chk("mode_edges", edge_cnt, 16);
            chk("mode_sclk_done", sclk, m[1]);
        end

        // LSB first: 0x01 on MOSI, slave sends 0x80 LSB first
        setup(3'd3, 1'b0, 1'b0, 1'b1, 8'd1, 8'h01, 1'b0, 8'h80, 1'b1);
        launch(lat);
        chk("lsb_latency", lat, 36);
        chk("lsb_mosi_rises", rise_bits, 8'h80);
        chk("lsb_rx", rx_data, 8'h80);
        chk("lsb_cs_and", cs_and, 4'b0111);

        // Start while busy ignored, start in done cycle accepted
        setup(3'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h5A, 1'b1, 8'h00, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        tx_data = 8'hFF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("b2b_first_latency", lat, 12);
        chk("b2b_first_rx", rx_data, 8'h5A);
        chk("b2b_cs_gap", cs_n, 4'hF);
        tx_data = 8'h3C;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_second_busy", busy, 1'b1);
        chk("b2b_second_cs", cs_n, 4'b1110);
        wait_done(lat);
        chk("b2b_second_latency", lat, 18);
        chk("b2b_second_rx", rx_data, 8'h3C);
        @(posedge clk); #1;
        chk("b2b_done_cnt", done_cnt, 2);

        // Out-of-range select: dummy clocks, no chip select
        setup(3'd5, 1'b0, 1'b0, 1'b0, 8'd0, 8'hC3, 1'b1, 8'h00, 1'b0);
        launch(lat);
        chk("dummy_latency", lat, 18);
        chk("dummy_edges", edge_cnt, 16);
        chk("dummy_cs_and", cs_and, 4'hF);
        chk("dummy_rx", rx_data, 8'hC3);
        @(posedge clk); #1;
        chk("dummy_done_cnt", done_cnt, 1);

        // Reset in the middle of XFER, then a clean transfer
        setup(3'd2, 1'b0, 1'b0, 1'b0, 8'd3, 8'h96, 1'b1, 8'h00, 1'b0);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (26) begin @(posedge clk); #1; end
        chk("rst_mid_busy_before", busy, 1'b1);
        reset = 1'b0;
        #1;
        chk("rst_mid_cs_n", cs_n, 4'hF);
        chk("rst_mid_sclk", sclk, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_rx", rx_data, 8'h00);
        #2;
        reset = 1'b1;
        repeat (5) begin @(posedge clk); #1; end
        chk("rst_mid_no_done", done_cnt, 0);
        setup(3'd2, 1'b0, 1'b0, 1'b0, 8'd3, 8'h69, 1'b1, 8'h00, 1'b0);
        launch(lat);
        chk("post_rst_latency", lat, 72);
        chk("post_rst_rx", rx_data, 8'h69);
        chk("post_rst_cs", cs_and, 4'b1011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
